integrate_dump_ctrl: RTL

INTEGRATE_DUMP_CTRL -- requirements
Module: integrate_dump_ctrl

---
 rtl/integrate_dump_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/integrate_dump_ctrl.sv
// Integrate-and-dump controller: sums len_i accepted signed samples, then holds the result until handshake.
// Define INTEGRATE_DUMP_SAT_EN for saturating accumulation with a sticky sat flag; otherwise the sum wraps.
module integrate_dump_ctrl #(
  parameter int I_BW   = 5,
  parameter int O_BW   = 8,
  parameter int CNT_BW = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     start_i,
  input  logic                     cont_i,
  input  logic        [CNT_BW-1:0] len_i,
  input  logic signed [I_BW-1:0]   data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic signed [O_BW-1:0]   data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     busy_o,
  output logic                     sat_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_t;

  state_t                  state_q, state_d;
  logic signed [O_BW-1:0]  acc_q, acc_d;
  logic        [CNT_BW-1:0] cnt_q, cnt_d;
  logic        [CNT_BW-1:0] len_q, len_d;
  logic                    sat_q, sat_d;
  logic        [O_BW:0]    add_res;
  logic        [CNT_BW-1:0] cnt_inc;

  // Returns {overflow, sum}; overflow is only ever set in the saturating build.
  function automatic logic [O_BW:0] add_sample(input logic signed [O_BW-1:0] acc,
                                               input logic signed [I_BW-1:0] d);
    logic signed [O_BW-1:0] dx;
    logic signed [O_BW-1:0] sum;
    logic                   ovf;
    dx  = O_BW'(d);
    sum = acc + dx;
`ifdef INTEGRATE_DUMP_SAT_EN
    ovf = (acc[O_BW-1] == dx[O_BW-1]) && (sum[O_BW-1] != acc[O_BW-1]);
    if (ovf) begin
      sum = acc[O_BW-1] ? {1'b1, {(O_BW-1){1'b0}}} : {1'b0, {(O_BW-1){1'b1}}};
    end
`else
    ovf = 1'b0;
`endif
    return {ovf, sum};
  endfunction

  assign add_res = add_sample(acc_q, data_i);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sat_d   = sat_q;
    if (!en_i) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && (len_i != '0)) begin
            state_d = ACCUM;
            len_d   = len_i;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
        end
        ACCUM: begin
          if (valid_i) begin
            acc_d = add_res[O_BW-1:0];
            sat_d = sat_q | add_res[O_BW];
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) state_d = DUMP;
          end
        end
        DUMP: begin
          if (ready_i) begin
            // Both exits start from a clean window; IDLE must also read zero on data_o.
            state_d = cont_i ? ACCUM : IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
    end
  end

  assign ready_o = (state_q == ACCUM);
  assign valid_o = (state_q == DUMP);
  assign busy_o  = (state_q != IDLE);
  assign data_o  = (state_q == IDLE) ? '0 : acc_q;
  assign sat_o   = sat_q;

endmodule
